// File: rtl/fp_mult_arbiter.sv
// rtl/fp_mult_arbiter.sv - round-robin arbiter sharing one fixed-latency FP multiplier between NREQ requesters
module fp_mult_arbiter #(
  parameter int NREQ = 4,
  parameter int LAT  = 1,
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*32-1:0] req_a,
  input  logic [NREQ*32-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic [31:0]       mul_a,
  output logic [31:0]       mul_b,
  input  logic [31:0]       mul_p,
  output logic              rsp_valid,
  output logic [IDW-1:0]    rsp_id,
  output logic [31:0]       rsp_p,
  input  logic              rsp_ready
);

  localparam int CW = $clog2(LAT) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t         state_q, state_d;
  logic [31:0]    mul_a_q, mul_a_d;
  logic [31:0]    mul_b_q, mul_b_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0] rsp_id_q, rsp_id_d;
  logic [31:0]    rsp_p_q, rsp_p_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [IDW-1:0] last_q, last_d;

  logic           grant_found;
  logic [IDW-1:0] grant_idx;

  // Search starts one past the previous winner so every valid requester is reached within NREQ-1 grants.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int j = 1; j <= NREQ; j++) begin
      if (!grant_found && req_valid[(int'(last_q) + j) % NREQ]) begin
        grant_found = 1'b1;
        grant_idx   = IDW'((int'(last_q) + j) % NREQ);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state_q == S_IDLE && grant_found) begin
      req_ready = {{(NREQ-1){1'b0}}, 1'b1} << grant_idx;
    end
  end

  always_comb begin
    state_d     = state_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_p_d     = rsp_p_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    case (state_q)
      S_IDLE: begin
        if (grant_found) begin
          mul_a_d  = req_a[32*int'(grant_idx) +: 32];
          mul_b_d  = req_b[32*int'(grant_idx) +: 32];
          rsp_id_d = grant_idx;
          last_d   = grant_idx;
          cnt_d    = CW'(LAT - 1);
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          rsp_p_d     = mul_p;
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_p_q     <= '0;
      cnt_q       <= '0;
      last_q      <= IDW'(NREQ - 1);
    end else begin
      state_q     <= state_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_p_q     <= rsp_p_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
    end
  end

  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_p     = rsp_p_q;

endmodule

// File: tb/tb_fp_mult_arbiter.sv
// tb/tb_fp_mult_arbiter.sv - bench for fp_mult_arbiter: transaction-level model plus directed vectors, LAT=1 and LAT=3 instances
module tb_fp_mult_arbiter;
  localparam int NREQ = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst;
  logic [NREQ-1:0]     req_valid [2];
  logic [NREQ*32-1:0]  req_a [2];
  logic [NREQ*32-1:0]  req_b [2];
  logic [NREQ-1:0]     req_ready [2];
  logic [31:0]         mul_a [2];
  logic [31:0]         mul_b [2];
  logic [31:0]         mul_p [2];
  logic                rsp_valid [2];
  logic [1:0]          rsp_id [2];
  logic [31:0]         rsp_p [2];
  logic                rsp_ready [2];

  for (genvar k = 0; k < 2; k++) begin : g_dut
    fp_mult_arbiter #(.NREQ(NREQ), .LAT(k == 0 ? 1 : 3)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid[k]),
      .req_a     (req_a[k]),
      .req_b     (req_b[k]),
      .req_ready (req_ready[k]),
      .mul_a     (mul_a[k]),
      .mul_b     (mul_b[k]),
      .mul_p     (mul_p[k]),
      .rsp_valid (rsp_valid[k]),
      .rsp_id    (rsp_id[k]),
      .rsp_p     (rsp_p[k]),
      .rsp_ready (rsp_ready[k])
    );
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;
  bit chk_on = 1'b0;

  bit          m_busy [2];
  int          m_t [2];
  int          m_last [2];
  int          m_id [2];
  logic [31:0] m_a [2];
  logic [31:0] m_b [2];
  logic [31:0] m_p [2];
  int          g_n [2];
  int          g_id [2][64];
  int          g_t [2][64];

  int              mg;
  bit              mexpv;
  logic [NREQ-1:0] mexp_rdy;

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  // Multiplier stand-in: exact IEEE products for the directed operands, an arbitrary mix otherwise.
  function automatic logic [31:0] prod(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      {32'h40000000, 32'h40400000}: return 32'h40C00000;
      {32'h3FC00000, 32'h3FC00000}: return 32'h40100000;
      {32'h40000000, 32'h40800000}: return 32'h41000000;
      default: return a ^ {b[15:0], b[31:16]};
    endcase
  endfunction

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d cyc=%0d: got %h want %h", name, k, cyc, act, exp);
    end
  endtask

  // Compare process: expected outputs from the transaction model, then advance the model.
  initial forever begin
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      mg = -1;
      for (int j = 1; j <= NREQ; j++)
        if (mg < 0 && req_valid[k][(m_last[k] + j) % NREQ]) mg = (m_last[k] + j) % NREQ;
      mexp_rdy = '0;
      if (!m_busy[k] && mg >= 0) mexp_rdy[mg] = 1'b1;
      mexpv = m_busy[k] && (cyc >= m_t[k] + lat_of(k) + 1);
      if (chk_on) begin
        chk("req_ready", k, 32'(req_ready[k]), 32'(mexp_rdy));
        chk("mul_a", k, mul_a[k], m_a[k]);
        chk("mul_b", k, mul_b[k], m_b[k]);
        chk("rsp_valid", k, 32'(rsp_valid[k]), 32'(mexpv));
        if (mexpv) begin
          chk("rsp_id", k, 32'(rsp_id[k]), 32'(m_id[k]));
          chk("rsp_p", k, rsp_p[k], m_p[k]);
        end
      end
      if (m_busy[k] && cyc == m_t[k] + lat_of(k)) begin
        m_p[k]   = prod(m_a[k], m_b[k]);
        mul_p[k] = m_p[k];
      end else begin
        mul_p[k] = 32'hDEADBEEF;
      end
      if (rst) begin
        m_busy[k] = 1'b0;
        m_last[k] = NREQ - 1;
        m_a[k]    = '0;
        m_b[k]    = '0;
      end else if (!m_busy[k] && mg >= 0) begin
        m_busy[k] = 1'b1;
        m_t[k]    = cyc;
        m_id[k]   = mg;
        m_last[k] = mg;
        m_a[k]    = req_a[k][32*mg +: 32];
        m_b[k]    = req_b[k][32*mg +: 32];
        if (g_n[k] < 64) begin
          g_id[k][g_n[k]] = mg;
          g_t[k][g_n[k]]  = cyc;
        end
        g_n[k]++;
      end else if (mexpv && rsp_ready[k]) begin
        m_busy[k] = 1'b0;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int k);
    int n;
    n = 0;
    while (m_busy[k] && n < 50) begin
      step(1);
      n++;
    end
    if (m_busy[k]) begin
      total++;
      bad++;
      $display("FAIL idle_timeout dut%0d: still busy after %0d cycles, want idle", k, n);
    end
  endtask

  task automatic wait_grants(input int k, input int target);
    int n;
    n = 0;
    while (g_n[k] < target && n < 60) begin
      step(1);
      n++;
    end
    if (g_n[k] < target) begin
      total++;
      bad++;
      $display("FAIL grant_timeout dut%0d: grants=%0d want %0d", k, g_n[k], target);
    end
  endtask

  int base;
  int n;
  int want2 [5] = '{0, 1, 2, 3, 0};
  int want4 [4] = '{1, 3, 1, 3};

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      req_valid[k] = '0;
      req_a[k]     = '0;
      req_b[k]     = '0;
      rsp_ready[k] = 1'b1;
    end
    step(3);
    rst = 1'b0;
    chk_on = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("reset_mul_a", k, mul_a[k], 32'h0);
      chk("reset_mul_b", k, mul_b[k], 32'h0);
      chk("reset_rsp_valid", k, 32'(rsp_valid[k]), 32'h0);
      chk("reset_rsp_p", k, rsp_p[k], 32'h0);
      chk("reset_req_ready", k, 32'(req_ready[k]), 32'h0);
    end

    // All four requesters continuously valid.
    for (int i = 0; i < NREQ; i++) begin
      req_a[0][32*i +: 32] = 32'h3F800000 + 32'(i * 16);
      req_b[0][32*i +: 32] = 32'h40A00000 + 32'(i * 256);
    end
    base = g_n[0];
    req_valid[0] = 4'hF;
    wait_grants(0, base + 5);
    req_valid[0] = '0;
    for (int i = 0; i < 5; i++) chk("t2_order", 0, 32'(g_id[0][base+i]), 32'(want2[i]));
    for (int i = 1; i < 5; i++) chk("t2_spacing", 0, 32'(g_t[0][base+i] - g_t[0][base+i-1]), 32'd3);
    wait_idle(0);

    // Single requester 2: 2.0 * 3.0.
    req_a[0][32*2 +: 32] = 32'h40000000;
    req_b[0][32*2 +: 32] = 32'h40400000;
    req_valid[0] = 4'b0100;
    #1;
    chk("t1_ready", 0, 32'(req_ready[0]), 32'h4);
    step(1);
    req_valid[0] = '0;
    chk("t1_not_yet_valid", 0, 32'(rsp_valid[0]), 32'h0);
    step(1);
    chk("t1_rsp_valid", 0, 32'(rsp_valid[0]), 32'h1);
    chk("t1_rsp_id", 0, 32'(rsp_id[0]), 32'h2);
    chk("t1_rsp_p", 0, rsp_p[0], 32'h40C00000);
    wait_idle(0);

    // Held response under backpressure: 1.5 * 1.5.
    req_a[0][31:0] = 32'h3FC00000;
    req_b[0][31:0] = 32'h3FC00000;
    req_valid[0] = 4'b0001;
    rsp_ready[0] = 1'b0;
    step(1);
    req_valid[0] = 4'b0010;
    step(1);
    for (int i = 0; i < 5; i++) begin
      chk("t3_rsp_valid", 0, 32'(rsp_valid[0]), 32'h1);
      chk("t3_rsp_p", 0, rsp_p[0], 32'h40100000);
      chk("t3_req_ready", 0, 32'(req_ready[0]), 32'h0);
      step(1);
    end
    rsp_ready[0] = 1'b1;

    // Requesters 1 and 3 alternate; 0 and 2 never win.
    base = g_n[0];
    req_valid[0] = 4'b1010;
    wait_grants(0, base + 4);
    req_valid[0] = '0;
    for (int i = 0; i < 4; i++) chk("t4_order", 0, 32'(g_id[0][base+i]), 32'(want4[i]));
    wait_idle(0);

    // Reset while waiting for the product.
    req_valid[0] = 4'b0100;
    step(1);
    req_valid[0] = '0;
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("t5_rsp_valid", 0, 32'(rsp_valid[0]), 32'h0);
    chk("t5_rsp_id", 0, 32'(rsp_id[0]), 32'h0);
    chk("t5_rsp_p", 0, rsp_p[0], 32'h0);
    chk("t5_mul_a", 0, mul_a[0], 32'h0);
    chk("t5_mul_b", 0, mul_b[0], 32'h0);
    req_valid[0] = 4'b1001;
    #1;
    chk("t5_first_grant", 0, 32'(req_ready[0]), 32'h1);
    step(1);
    req_valid[0] = '0;
    wait_idle(0);

    // LAT=3 instance: garbage on mul_p except at the sampling cycle.
    req_a[1][31:0] = 32'h40000000;
    req_b[1][31:0] = 32'h40800000;
    req_valid[1] = 4'b0001;
    step(1);
    req_valid[1] = '0;
    n = 1;
    while (rsp_valid[1] !== 1'b1 && n < 12) begin
      step(1);
      n++;
    end
    chk("t6_first_valid_offset", 1, 32'(n), 32'd4);
    chk("t6_rsp_p", 1, rsp_p[1], 32'h41000000);
    chk("t6_rsp_id", 1, 32'(rsp_id[1]), 32'h0);
    wait_idle(1);

    step(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
